// File: rtl/alarm_ctrl.sv
// Alarm controller: holds a BCD alarm time, detects the HH:MM:00 match and
// sequences IDLE/RING/SNOOZE with one-second tick counters.
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       Tick_1Hz,
  input  logic [3:0] Hour_H,
  input  logic [3:0] Hour_L,
  input  logic [3:0] Min_H,
  input  logic [3:0] Min_L,
  input  logic [3:0] Sec_H,
  input  logic [3:0] Sec_L,
  input  logic       Alarm_EN,
  input  logic       Set_Mode,
  input  logic       Set_Sel,
  input  logic       Inc,
  input  logic       Stop,
  input  logic       Snooze,
  output logic [3:0] AHour_H,
  output logic [3:0] AHour_L,
  output logic [3:0] AMin_H,
  output logic [3:0] AMin_L,
  output logic       Ring,
  output logic       Snoozing,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;

  localparam logic [7:0] RING_LOAD   = 8'(RING_SEC);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);

  state_t     state, state_n;
  logic [7:0] ring_cnt, ring_cnt_n;
  logic [9:0] snz_cnt, snz_cnt_n;
  logic       inc_q, stop_q, snz_q, match_q, post_rst;
  logic       inc_e, stop_e, snz_e, match, trigger;
  logic [3:0] ahh_n, ahl_n, amh_n, aml_n;

  assign inc_e  = Inc & ~inc_q;
  assign stop_e = Stop & ~stop_q;
  assign snz_e  = Snooze & ~snz_q;
  assign match  = (Hour_H == AHour_H) && (Hour_L == AHour_L) &&
                  (Min_H == AMin_H) && (Min_L == AMin_L) &&
                  (Sec_H == 4'd0) && (Sec_L == 4'd0);
  // post_rst masks the first cycle after reset, when match_q is still 0
  // even though the time may already be sitting on the alarm value.
  assign trigger   = match & ~match_q & ~post_rst;
  assign dbg_state = state;

  always_comb begin
    ahh_n = AHour_H;
    ahl_n = AHour_L;
    amh_n = AMin_H;
    aml_n = AMin_L;
    if (inc_e && Set_Mode) begin
      if (!Set_Sel) begin
        if (AHour_H == 4'd2 && AHour_L == 4'd3) begin
          ahh_n = 4'd0;
          ahl_n = 4'd0;
        end else if (AHour_L == 4'd9) begin
          ahh_n = AHour_H + 4'd1;
          ahl_n = 4'd0;
        end else begin
          ahl_n = AHour_L + 4'd1;
        end
      end else begin
        if (AMin_L == 4'd9) begin
          aml_n = 4'd0;
          amh_n = (AMin_H == 4'd5) ? 4'd0 : AMin_H + 4'd1;
        end else begin
          aml_n = AMin_L + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    snz_cnt_n  = snz_cnt;
    if (!Alarm_EN || Set_Mode) begin
      state_n    = IDLE;
      ring_cnt_n = 8'd0;
      snz_cnt_n  = 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_n    = RING;
            ring_cnt_n = RING_LOAD;
          end
        end
        RING: begin
          if (stop_e) begin
            state_n    = IDLE;
            ring_cnt_n = 8'd0;
          end else if (snz_e) begin
            state_n    = SNOOZE;
            ring_cnt_n = 8'd0;
            snz_cnt_n  = SNOOZE_LOAD;
          end else if (Tick_1Hz) begin
            if (ring_cnt <= 8'd1) begin
              state_n    = IDLE;
              ring_cnt_n = 8'd0;
            end else begin
              ring_cnt_n = ring_cnt - 8'd1;
            end
          end
        end
        SNOOZE: begin
          if (stop_e) begin
            state_n   = IDLE;
            snz_cnt_n = 10'd0;
          end else if (Tick_1Hz) begin
            if (snz_cnt <= 10'd1) begin
              state_n    = RING;
              snz_cnt_n  = 10'd0;
              ring_cnt_n = RING_LOAD;
            end else begin
              snz_cnt_n = snz_cnt - 10'd1;
            end
          end
        end
        default: begin
          state_n    = IDLE;
          ring_cnt_n = 8'd0;
          snz_cnt_n  = 10'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (!nCR) begin
      state    <= IDLE;
      ring_cnt <= 8'd0;
      snz_cnt  <= 10'd0;
      inc_q    <= 1'b0;
      stop_q   <= 1'b0;
      snz_q    <= 1'b0;
      match_q  <= 1'b0;
      post_rst <= 1'b1;
      AHour_H  <= 4'd0;
      AHour_L  <= 4'd0;
      AMin_H   <= 4'd0;
      AMin_L   <= 4'd0;
      Ring     <= 1'b0;
      Snoozing <= 1'b0;
    end else begin
      state    <= state_n;
      ring_cnt <= ring_cnt_n;
      snz_cnt  <= snz_cnt_n;
      inc_q    <= Inc;
      stop_q   <= Stop;
      snz_q    <= Snooze;
      match_q  <= match;
      post_rst <= 1'b0;
      AHour_H  <= ahh_n;
      AHour_L  <= ahl_n;
      AMin_H   <= amh_n;
      AMin_L   <= aml_n;
      Ring     <= (state_n == RING);
      Snoozing <= (state_n == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: alarm-time editing, ring/snooze timing,
// request priority and reset behaviour, against hand-computed values.
module tb_alarm_ctrl;

  logic       CP = 1'b0;
  logic       nCR, Tick_1Hz, Alarm_EN, Set_Mode, Set_Sel, Inc, Stop, Snooze;
  logic [3:0] Hour_H, Hour_L, Min_H, Min_L, Sec_H, Sec_L;
  logic [3:0] AHour_H, AHour_L, AMin_H, AMin_L;
  logic       Ring, Snoozing;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  alarm_ctrl #(.RING_SEC(60), .SNOOZE_MIN(5)) dut (
    .CP(CP), .nCR(nCR), .Tick_1Hz(Tick_1Hz),
    .Hour_H(Hour_H), .Hour_L(Hour_L), .Min_H(Min_H), .Min_L(Min_L),
    .Sec_H(Sec_H), .Sec_L(Sec_L),
    .Alarm_EN(Alarm_EN), .Set_Mode(Set_Mode), .Set_Sel(Set_Sel),
    .Inc(Inc), .Stop(Stop), .Snooze(Snooze),
    .AHour_H(AHour_H), .AHour_L(AHour_L), .AMin_H(AMin_H), .AMin_L(AMin_L),
    .Ring(Ring), .Snoozing(Snoozing), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks: all called and returning at a negedge
  task automatic cyc(input int n);
    repeat (n) @(negedge CP);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    Hour_H = h[7:4]; Hour_L = h[3:0];
    Min_H  = m[7:4]; Min_L  = m[3:0];
    Sec_H  = s[7:4]; Sec_L  = s[3:0];
  endtask

  task automatic inc_n(input int n);
    for (int i = 0; i < n; i++) begin
      Inc = 1'b1; cyc(2);
      Inc = 1'b0; cyc(2);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      Tick_1Hz = 1'b1; cyc(1);
      Tick_1Hz = 1'b0;
    end
  endtask

  task automatic pulse_req(input logic s, input logic z);
    Stop = s; Snooze = z; cyc(1);
    Stop = 1'b0; Snooze = 1'b0; cyc(1);
  endtask

  // time leaves 07:30:00 then returns, giving a fresh Match rising edge
  task automatic retrigger();
    set_time(8'h07, 8'h30, 8'h01); cyc(1);
    set_time(8'h07, 8'h30, 8'h00); cyc(1);
  endtask

  initial begin
    nCR = 1'b0; Tick_1Hz = 1'b0; Alarm_EN = 1'b0; Set_Mode = 1'b0;
    Set_Sel = 1'b0; Inc = 1'b0; Stop = 1'b0; Snooze = 1'b0;
    set_time(8'h00, 8'h00, 8'h00);
    cyc(3);
    nCR = 1'b1;
    cyc(1);
    check("rst_ahour", {AHour_H, AHour_L}, 16'h0000);
    check("rst_amin",  {AMin_H, AMin_L},   16'h0000);
    check("rst_ring",  Ring,     1'b0);
    check("rst_snz",   Snoozing, 1'b0);
    check("rst_state", dbg_state, 2'd0);

    // hour editing with carry and 23 -> 00 wrap
    Set_Mode = 1'b1; Set_Sel = 1'b0;
    inc_n(10); check("hour_10",   {AHour_H, AHour_L}, 16'h0010);
    inc_n(14); check("hour_wrap", {AHour_H, AHour_L}, 16'h0000);
    inc_n(1);  check("hour_25",   {AHour_H, AHour_L}, 16'h0001);
    // minute editing, 59 -> 00 without hour carry
    Set_Sel = 1'b1;
    inc_n(59); check("min_59",    {AMin_H, AMin_L},   16'h0059);
    inc_n(1);  check("min_wrap",  {AMin_H, AMin_L},   16'h0000);
    check("min_nocarry", {AHour_H, AHour_L}, 16'h0001);
    inc_n(1);  check("min_61",    {AMin_H, AMin_L},   16'h0001);
    // held Inc level counts once
    Inc = 1'b1; cyc(100); Inc = 1'b0; cyc(2);
    check("inc_held", {AMin_H, AMin_L}, 16'h0002);
    inc_n(28);
    Set_Sel = 1'b0;
    inc_n(6);
    check("set_ahour", {AHour_H, AHour_L}, 16'h0007);
    check("set_amin",  {AMin_H, AMin_L},   16'h0030);
    // Inc ignored outside set mode
    Set_Mode = 1'b0; Set_Sel = 1'b1;
    inc_n(1);
    check("inc_ignored", {AMin_H, AMin_L}, 16'h0030);

    // alarm at 07:30:00 rings one cycle after match, for 60 ticks
    Alarm_EN = 1'b1;
    set_time(8'h07, 8'h29, 8'h59); cyc(2);
    check("pre_match_ring", Ring, 1'b0);
    set_time(8'h07, 8'h30, 8'h00); cyc(1);
    check("ring_on",    Ring, 1'b1);
    check("ring_state", dbg_state, 2'd1);
    tick_n(59); check("ring_59", Ring, 1'b1);
    tick_n(1);  check("ring_60", Ring, 1'b0);
    check("ring_idle", dbg_state, 2'd0);
    cyc(5);     check("no_retrig_held", Ring, 1'b0);

    // snooze for 300 ticks, then ring again; Snooze in SNOOZE ignored
    retrigger(); check("ring2_on", Ring, 1'b1);
    tick_n(3);
    pulse_req(1'b0, 1'b1);
    check("snz_ring", Ring, 1'b0);
    check("snz_on",   Snoozing, 1'b1);
    pulse_req(1'b0, 1'b1);
    tick_n(299);
    check("snz_299",  Snoozing, 1'b1);
    check("snz_299r", Ring, 1'b0);
    tick_n(1);
    check("snz_300r", Ring, 1'b1);
    check("snz_300s", Snoozing, 1'b0);
    // reloaded ring count: 59 ticks still ringing
    tick_n(59); check("reload_59", Ring, 1'b1);
    pulse_req(1'b1, 1'b0);
    check("stop_ring", Ring, 1'b0);
    check("stop_snz",  Snoozing, 1'b0);

    // Stop in SNOOZE
    retrigger(); pulse_req(1'b0, 1'b1);
    check("snz2_on", Snoozing, 1'b1);
    pulse_req(1'b1, 1'b0);
    check("snz_stop", {Ring, Snoozing}, 2'b00);

    // Stop beats Snooze in the same cycle
    retrigger(); check("ring3_on", Ring, 1'b1);
    pulse_req(1'b1, 1'b1);
    check("stop_snz_ring", Ring, 1'b0);
    check("stop_snz_snz",  Snoozing, 1'b0);
    check("stop_snz_idle", dbg_state, 2'd0);

    // disabling forces IDLE; re-enabling at a held match does not retrigger
    retrigger(); check("ring4_on", Ring, 1'b1);
    Alarm_EN = 1'b0; cyc(1);
    check("dis_ring", Ring, 1'b0);
    Alarm_EN = 1'b1; cyc(5);
    check("en_no_retrig", Ring, 1'b0);

    // Set_Mode forces IDLE out of SNOOZE
    retrigger(); pulse_req(1'b0, 1'b1);
    Set_Mode = 1'b1; cyc(1);
    check("setmode_snz", {Ring, Snoozing}, 2'b00);
    Set_Mode = 1'b0; cyc(2);

    // reset mid-RING while time already equals the reset alarm (00:00)
    retrigger(); check("ring5_on", Ring, 1'b1);
    set_time(8'h00, 8'h00, 8'h00);
    nCR = 1'b0; cyc(1);
    check("rst_mid_ring", Ring, 1'b0);
    check("rst_mid_ah",   {AHour_H, AHour_L, AMin_H, AMin_L}, 16'h0000);
    cyc(2);
    check("rst_hold", Ring, 1'b0);
    nCR = 1'b1; cyc(5);
    check("rst_no_trig", Ring, 1'b0);
    set_time(8'h00, 8'h00, 8'h01); cyc(1);
    set_time(8'h00, 8'h00, 8'h00); cyc(1);
    check("rst_then_rise", Ring, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60, ring duration in Tick_1Hz ticks (legal 1..255).
REQ-002 Parameter SNOOZE_MIN, default 5, snooze delay in minutes (legal 1..9).
REQ-003 Port CP  input  1  system clock; all state updates on posedge CP.
REQ-004 Port nCR  input  1  reset, synchronous, active-low; sampled on posedge CP only.
REQ-005 Port Tick_1Hz  input  1  one-CP-cycle pulse, once per second, synchronous to CP.
REQ-006 Port Hour_H, Hour_L, Min_H, Min_L, Sec_H, Sec_L  input  4 each  current time, BCD digits from the time counters.
REQ-007 Port Alarm_EN  input  1  alarm armed when 1.
REQ-008 Port Set_Mode  input  1  alarm-time edit mode when 1.
REQ-009 Port Set_Sel  input  1  edit field select: 0 = hours, 1 = minutes.
REQ-010 Port Inc  input  1  increment request, debounced level, synchronous to CP.
REQ-011 Port Stop, Snooze  input  1 each  user requests, debounced levels, synchronous to CP.
REQ-012 Port AHour_H, AHour_L, AMin_H, AMin_L  output  4 each  stored alarm time, BCD.
REQ-013 Port Ring  output  1  buzzer drive, 1 while in RING.
REQ-014 Port Snoozing  output  1  1 while in SNOOZE.

Function
REQ-015 Inc, Stop, Snooze SHALL each be rising-edge detected internally (registered previous value); each action fires once per 0->1 transition, one cycle after the transition is sampled.
REQ-016 Inc edge with Set_Mode=1, Set_Sel=0 SHALL advance alarm hours in BCD 00..23, 23 -> 00; AHour_L wraps 9 -> 0 with AHour_H carry.
REQ-017 Inc edge with Set_Mode=1, Set_Sel=1 SHALL advance alarm minutes in BCD 00..59, 59 -> 00, no carry into hours.
REQ-018 Inc edges with Set_Mode=0 SHALL be ignored.
REQ-019 Match SHALL be true when Hour_H/L = AHour_H/L, Min_H/L = AMin_H/L, Sec_H = 0 and Sec_L = 0.
REQ-020 Match SHALL be edge-detected: a trigger occurs only on the cycle Match goes 0 -> 1.
REQ-021 FSM states: IDLE, RING, SNOOZE; encoding free; no other reachable state.
REQ-022 IDLE -> RING on trigger when Alarm_EN=1 and Set_Mode=0; ring counter loads RING_SEC.
REQ-023 RING: ring counter decrements on each Tick_1Hz; at value 1 with Tick_1Hz -> IDLE.
REQ-024 RING -> IDLE on Stop edge.
REQ-025 RING -> SNOOZE on Snooze edge; snooze counter (10 bits) loads SNOOZE_MIN*60.
REQ-026 SNOOZE: snooze counter decrements on each Tick_1Hz; at value 1 with Tick_1Hz -> RING, ring counter reloads RING_SEC.
REQ-027 SNOOZE -> IDLE on Stop edge; Snooze edges in SNOOZE ignored.
REQ-028 Any state -> IDLE when Alarm_EN=0 or Set_Mode=1, counters cleared.
REQ-029 Same-cycle priority: nCR > (Alarm_EN=0 or Set_Mode=1) > Stop > Snooze > tick expiry > trigger.
REQ-030 Trigger while in RING or SNOOZE SHALL be ignored (no counter reload).
REQ-031 Ring and Snoozing SHALL be registered, decoded from state, never both 1.
REQ-032 Alarm-time edits SHALL be possible only in IDLE (guaranteed by REQ-028).

Reset
REQ-033 nCR=0 at posedge CP SHALL set state IDLE, Ring=0, Snoozing=0, both counters 0, edge-detect registers 0, alarm time 00:00.
REQ-034 nCR=0 mid-RING or mid-SNOOZE SHALL take effect at that edge; no trigger may fire on the first cycle after release unless Match rises afterwards.
REQ-035 nCR SHALL have no asynchronous effect; outputs hold between edges while nCR=0.

Verification
REQ-036 Reset, Set_Mode=1, Set_Sel=0, 25 Inc edges -> alarm hours 01; Set_Sel=1, 61 Inc edges -> minutes 01.
REQ-037 Alarm 07:30, Alarm_EN=1, time steps to 07:30:00 -> Ring=1 next cycle; 60 ticks later Ring=0, IDLE.
REQ-038 Ringing, Snooze edge -> Ring=0, Snoozing=1; 300 ticks -> Ring=1, Snoozing=0; Stop edge -> IDLE.
REQ-039 Stop and Snooze edges same cycle in RING -> IDLE, Snoozing stays 0.
REQ-040 Ringing, Alarm_EN=0 -> IDLE next cycle; time held at 07:30:00 with Alarm_EN back to 1 -> no retrigger.
REQ-041 Held Inc level for 100 cycles in set mode -> exactly one increment.
